// File: rtl/float_addsub_seq.sv
// Sequential floating-point adder/subtractor: IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE.
// Rounding mode: define FADD_ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncation.
module float_addsub_seq #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int D   = MANT_W + 4;
  localparam int LZW = $clog2(D + 1);
  localparam int EW  = EXP_W + LZW + 2;
  localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic                 r_sub;
  logic                 r_sign;
  logic                 r_eff_sub;
  logic signed [EW-1:0] r_exp;
  logic [D-1:0]         r_big;
  logic [D-1:0]         r_sml;
  logic [D:0]           r_sum;
  logic [D-1:0]         r_sig;
  logic [W-1:0]         r_result;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic                 w_a_ge;
  logic [W-2:0]         w_big_op;
  logic [W-2:0]         w_sml_op;
  logic                 w_big_sign;
  logic                 w_eff_sub;
  logic [EXP_W-1:0]     w_big_exp;
  logic [EXP_W-1:0]     w_sml_exp;
  logic [EXP_W-1:0]     w_shamt;
  logic [D-1:0]         w_big_sig;
  logic [D-1:0]         w_sml_sig;
  logic [D-1:0]         w_sml_mask;
  logic                 w_lost;
  logic [D-1:0]         w_sml_aln;
  logic [LZW-1:0]       w_lzc;
  logic                 w_zero;
  logic                 w_inc;
  logic [MANT_W:0]      w_man_rnd;
  logic                 w_carry;
  logic signed [EW-1:0] w_rnd_exp;
  logic [W-1:0]         w_pack_result;
  logic                 w_pack_of;
  logic                 w_pack_uf;

  // Leading-zero count of the unsigned sum; the highest set bit wins.
  function automatic logic [LZW-1:0] lzc_f(input logic [D-1:0] v);
    lzc_f = LZW'(D);
    for (int i = 0; i < D; i++) begin
      lzc_f = v[i] ? LZW'(D - 1 - i) : lzc_f;
    end
  endfunction

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? ALIGN : IDLE;
      ALIGN:   w_state_nxt = ADD;
      ADD:     w_state_nxt = NORM;
      NORM:    w_state_nxt = PACK;
      PACK:    w_state_nxt = DONE;
      DONE:    w_state_nxt = out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand ordering and alignment; a zero exponent field means an exact zero.
  always_comb begin
    w_a_ge = (r_a[W-2:0] >= r_b[W-2:0]);
    if (w_a_ge) begin
      w_big_op   = r_a[W-2:0];
      w_sml_op   = r_b[W-2:0];
      w_big_sign = r_a[W-1];
    end else begin
      w_big_op   = r_b[W-2:0];
      w_sml_op   = r_a[W-2:0];
      w_big_sign = r_b[W-1] ^ r_sub;
    end
    w_eff_sub  = (r_a[W-1] ^ r_b[W-1] ^ r_sub) &
                 ~((r_a[W-2:MANT_W] == {EXP_W{1'b0}}) && (r_b[W-2:MANT_W] == {EXP_W{1'b0}}));
    w_big_exp  = w_big_op[W-2:MANT_W];
    w_sml_exp  = w_sml_op[W-2:MANT_W];
    w_big_sig  = (w_big_exp == {EXP_W{1'b0}}) ? {D{1'b0}} : {1'b1, w_big_op[MANT_W-1:0], 3'b000};
    w_sml_sig  = (w_sml_exp == {EXP_W{1'b0}}) ? {D{1'b0}} : {1'b1, w_sml_op[MANT_W-1:0], 3'b000};
    w_shamt    = w_big_exp - w_sml_exp;
    w_sml_mask = ~({D{1'b1}} << w_shamt);
    w_lost     = |(w_sml_sig & w_sml_mask);
    w_sml_aln  = (w_sml_sig >> w_shamt) | {{(D-1){1'b0}}, w_lost};
  end

  assign w_lzc = lzc_f(r_sum[D-1:0]);

  // Rounding and final packing with saturation / flush-to-zero.
  always_comb begin
`ifdef FADD_ROUND_NEAREST_EN
    w_inc = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
`else
    w_inc = 1'b0;
`endif
    w_zero        = (r_sig == {D{1'b0}});
    w_man_rnd     = {1'b0, r_sig[D-2:3]} + {{MANT_W{1'b0}}, w_inc};
    w_carry       = w_man_rnd[MANT_W];
    w_rnd_exp     = r_exp + {{(EW-1){1'b0}}, w_carry};
    w_pack_result = {W{1'b0}};
    w_pack_of     = 1'b0;
    w_pack_uf     = 1'b0;
    if (w_zero) begin
      w_pack_result = {W{1'b0}};
    end else if (r_exp <= EXP_ZERO) begin
      w_pack_result = {r_sign, {(W-1){1'b0}}};
      w_pack_uf     = 1'b1;
    end else if (w_rnd_exp >= EXP_SAT) begin
      w_pack_result = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      w_pack_of     = 1'b1;
    end else begin
      w_pack_result = {r_sign, w_rnd_exp[EXP_W-1:0], w_man_rnd[MANT_W-1:0]};
    end
  end

  // Datapath: each stage register is written only in its own state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_sub       <= 1'b0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_exp       <= EXP_ZERO;
      r_big       <= {D{1'b0}};
      r_sml       <= {D{1'b0}};
      r_sum       <= {(D+1){1'b0}};
      r_sig       <= {D{1'b0}};
      r_result    <= {W{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
          end else begin
            r_a   <= r_a;
          end
        end
        ALIGN: begin
          r_sign    <= w_big_sign;
          r_eff_sub <= w_eff_sub;
          r_exp     <= {{(EW-EXP_W){1'b0}}, w_big_exp};
          r_big     <= w_big_sig;
          r_sml     <= w_sml_aln;
        end
        ADD: begin
          r_sum <= r_eff_sub ? ({1'b0, r_big} - {1'b0, r_sml}) : ({1'b0, r_big} + {1'b0, r_sml});
        end
        NORM: begin
          // A carry-out keeps the dropped bit in sticky; otherwise left-justify the hidden bit.
          if (r_sum[D]) begin
            r_sig <= {r_sum[D:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EXP_ONE;
          end else begin
            r_sig <= r_sum[D-1:0] << w_lzc;
            r_exp <= r_exp - {{(EW-LZW){1'b0}}, w_lzc};
          end
        end
        PACK: begin
          r_result    <= w_pack_result;
          r_overflow  <= w_pack_of;
          r_underflow <= w_pack_uf;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_float_addsub_seq.sv
// Self-checking bench for float_addsub_seq: directed cases plus random operands against
// an exact-integer reference model. Honours FADD_ROUND_NEAREST_EN like the design.
module tb_float_addsub_seq;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int W      = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  float_addsub_seq #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact reference: each operand as an integer in units of the smallest normal ulp.
  function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic [W-1:0] r, output logic of, output logic uf);
    longint va, vb, sum, mag, q, rem, half;
    int ea, eb, p, e, sh;
    logic sgn;
    ea = int'(x[14:10]);
    eb = int'(y[14:10]);
    va = (ea == 0) ? 64'sd0 : (longint'({1'b1, x[9:0]}) << (ea - 1));
    vb = (eb == 0) ? 64'sd0 : (longint'({1'b1, y[9:0]}) << (eb - 1));
    if (x[15]) va = -va;
    if (y[15] ^ s) vb = -vb;
    sum = va + vb;
    r = 16'h0000; of = 1'b0; uf = 1'b0;
    if (sum == 0) return;
    sgn = (sum < 0);
    mag = sgn ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = p - MANT_W + 1;
    if (e <= 0) begin
      r = {sgn, 15'h0000};
      uf = 1'b1;
      return;
    end
    sh  = p - MANT_W;
    q   = mag >> sh;
    rem = mag - (q << sh);
`ifdef FADD_ROUND_NEAREST_EN
    if (sh > 0) begin
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
`else
    half = rem;
`endif
    if (q == (longint'(1) << (MANT_W + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= (1 << EXP_W) - 1) begin
      r = {sgn, 5'h1F, 10'h000};
      of = 1'b1;
    end else begin
      r = {sgn, 5'(e), q[9:0]};
    end
  endfunction

  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_const(input string tag, input logic [W-1:0] er, input logic eo, input logic eu);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, eu});
  endtask

  task automatic op_model(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
    logic [W-1:0] er;
    logic eo, eu;
    ref_model(xa, xb, xs, er, eo, eu);
    start_op(xa, xb, xs);
    wait_done(tag);
    check_const(tag, er, eo, eu);
    release_out();
  endtask

  task automatic op_const(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                          input logic [W-1:0] er, input logic eo, input logic eu);
    start_op(xa, xb, xs);
    wait_done(tag);
    check_const(tag, er, eo, eu);
    release_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [4:0] ea, eb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_const("rst", 16'h0000, 1'b0, 1'b0);

    op_const("sub_8_5", 16'h4800, 16'h4500, 1'b1, 16'h4200, 1'b0, 1'b0);
    op_const("add_1_1", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
    op_const("cancel", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
    op_const("ovf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
    op_const("unf", 16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 1'b1);
`ifdef FADD_ROUND_NEAREST_EN
    op_const("round", 16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0);
`else
    op_const("round", 16'h3C01, 16'h1000, 1'b0, 16'h3C01, 1'b0, 1'b0);
`endif
    op_const("zero_plus_x", 16'h0155, 16'hC500, 1'b0, 16'hC500, 1'b0, 1'b0);

    // Backpressure in DONE with a competing request on the input.
    start_op(16'h3C00, 16'h3C00, 1'b0);
    wait_done("hold");
    a = 16'h5555; b = 16'h1234; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_const("hold", 16'h4000, 1'b0, 1'b0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    op_model("after_hold", 16'h4A00, 16'hC100, 1'b0);

    // Reset while the operation sits in NORM.
    start_op(16'h4800, 16'h4500, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_const("midrst", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);

    for (int k = 0; k < 300; k++) begin
      ea = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) eb = 5'($urandom_range(0, 31));
      else eb = 5'(int'(ea) + 2 - int'($urandom_range(0, 4)));
      ra = {1'($urandom_range(0, 1)), ea, 10'($urandom)};
      rb = {1'($urandom_range(0, 1)), eb, 10'($urandom)};
      if ($urandom_range(0, 7) == 0) rb = {~ra[15], ra[14:0]};
      op_model("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/float_addsub_seq.md
FLOAT_ADDSUB_SEQ -- requirements
Module: float_addsub_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-002 The block SHALL have parameter MANT_W, default 10, meaning stored mantissa width (hidden 1 implicit); word width W = 1+EXP_W+MANT_W, bias = 2^(EXP_W-1)-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair a/b/sub is valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  W  operand A, IEEE-754 style {sign, exp, mant}.
REQ-008 b  input  W  operand B, same format.
REQ-009 sub  input  1  1: result = a - b; 0: result = a + b.
REQ-010 out_valid  output  1  result/flags are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  W  packed sum/difference.
REQ-013 overflow  output  1  result saturated to infinity pattern.
REQ-014 underflow  output  1  result flushed to zero from non-zero true value.

Function
REQ-015 FSM states SHALL be IDLE, ALIGN, ADD, NORM, PACK, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->ALIGN on in_valid&&in_ready, capturing a, b, sub; ALIGN->ADD->NORM->PACK->DONE unconditionally, one cycle each; DONE->IDLE on out_ready, else hold.
REQ-017 Latency SHALL be fixed: out_valid rises after the 5th rising edge following the accepting edge (edges 1-4 are ALIGN..PACK); result, overflow, underflow SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 Operand with exp field 0 SHALL be treated as exact zero (no subnormals); all other exp values, including all-ones, are ordinary finite numbers with hidden 1.
REQ-019 Effective B sign = b.sign XOR sub; when both operands are zero, or effective signs equal, magnitudes add, otherwise subtract.
REQ-020 ALIGN: larger-magnitude operand selected by {exp, mant} compare (equal exponents resolved by mantissa); smaller significand right-shifted by exponent difference into a MANT_W+4 bit datapath (hidden bit, MANT_W bits, guard, round, sticky); bits shifted out OR into sticky; shift >= MANT_W+3 leaves only sticky.
REQ-021 ADD: magnitude add or subtract larger minus smaller; result sign = sign of larger-magnitude operand.
REQ-022 NORM: carry-out -> shift right 1, exponent +1, sticky preserved; else left-shift by leading-zero count (priority encoder, one cycle), exponent minus count.
REQ-023 Exact cancellation (difference zero) SHALL yield result = all zeros (positive zero), no flags.
REQ-024 Normalised exponent >= 2^EXP_W-1 SHALL yield {sign, all-ones, zero mant}, overflow=1.
REQ-025 Normalised exponent <= 0 for a non-zero value SHALL yield {sign, zero, zero}, underflow=1.
REQ-026 Rounding in PACK per REQ-032; a rounding carry into the hidden bit SHALL increment exponent and re-check REQ-024.
REQ-027 in_valid while not in IDLE SHALL be ignored (no capture, no corruption).

Reset
REQ-028 reset SHALL force state IDLE within the same edge, regardless of current state, discarding any in-flight operation.
REQ-029 After reset: in_ready=1, out_valid=0, result=0, overflow=0, underflow=0.
REQ-030 reset SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-031 Macro FADD_ROUND_NEAREST_EN SHALL select the rounding mode at compile time.
REQ-032 Defined: round-to-nearest, ties-to-even using guard/round/sticky; undefined: truncation toward zero (guard/round/sticky discarded); FSM, latency and flags identical in both builds.

Verification (defaults EXP_W=5, MANT_W=10)
REQ-033 a=0x4800 (8.0), b=0x4500 (5.0), sub=1 -> result=0x4200 (3.0), flags 0, out_valid after 5th edge.
REQ-034 a=0x3C00, b=0x3C00, sub=0 -> 0x4000; a=0x3C00, b=0x3C00, sub=1 -> 0x0000, flags 0.
REQ-035 a=0x7BFF, b=0x7BFF, sub=0 -> 0x7C00, overflow=1; a=0x0400, b=0x0401, sub=1 -> 0x8000, underflow=1.
REQ-036 a=0x3C01, b=0x1000, sub=0 -> 0x3C02 with FADD_ROUND_NEAREST_EN, 0x3C01 without.
REQ-037 Hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no capture; then out_ready=1 -> IDLE, next pair accepted.
REQ-038 Assert reset during NORM -> next cycle IDLE, out_valid=0, all outputs 0, in_ready=1.
